// File: rtl/axi4lite_pkg.sv
// Shared types for the AXI4-Lite master: response codes, master FSM
// states and a helper that names the states in which the master waits
// on the bus.
package axi4lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } mst_state_t;

  // States in which the master is waiting on a responder handshake; only
  // these may raise the sticky timeout flag.
  function automatic logic is_wait_state(input mst_state_t s);
    return (s == WR) || (s == WR_RESP) || (s == RD_ADDR) || (s == RD_DATA);
  endfunction

endpackage

// File: rtl/axi4lite_wdog.sv
// Saturating watchdog counter. Counts enabled cycles since the last clear,
// stops at TIMEOUT and reports expired while sitting there.
module axi4lite_wdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up while enabled until the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/axi4lite_master.sv
// AXI4-Lite initiator. Converts a single-beat command/response port into
// AXI4-Lite read or write transactions, one at a time. Every output comes
// straight from a register. A watchdog raises a sticky timeout flag when a
// bus phase waits too long, without ever withdrawing a pending VALID.
module axi4lite_master
  import axi4lite_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                A_CLK,
  input  logic                A_RST,
  // command port
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [2:0]          cmd_prot,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  // response port
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                timeout,
  // write address channel
  output logic [ADDR_W-1:0]   AW_ADDR,
  output logic [2:0]          AW_PROT,
  output logic                AW_VALID,
  input  logic                AW_READY,
  // write data channel
  output logic [DATA_W-1:0]   W_DATA,
  output logic [DATA_W/8-1:0] W_STRB,
  output logic                W_VALID,
  input  logic                W_READY,
  // write response channel
  input  logic [1:0]          B_RESP,
  input  logic                B_VALID,
  output logic                B_READY,
  // read address channel
  output logic [ADDR_W-1:0]   AR_ADDR,
  output logic [2:0]          AR_PROT,
  output logic                AR_VALID,
  input  logic                AR_READY,
  // read data channel
  input  logic [DATA_W-1:0]   R_DATA,
  input  logic [1:0]          R_RESP,
  input  logic                R_VALID,
  output logic                R_READY
);

  localparam int unsigned STRB_W = DATA_W / 8;

  mst_state_t          state_q,     state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic [ADDR_W-1:0]   awaddr_q,    awaddr_d;
  logic [2:0]          awprot_q,    awprot_d;
  logic                awvalid_q,   awvalid_d;
  logic [DATA_W-1:0]   wdata_q,     wdata_d;
  logic [STRB_W-1:0]   wstrb_q,     wstrb_d;
  logic                wvalid_q,    wvalid_d;
  logic                bready_q,    bready_d;
  logic [ADDR_W-1:0]   araddr_q,    araddr_d;
  logic [2:0]          arprot_q,    arprot_d;
  logic                arvalid_q,   arvalid_d;
  logic                rready_q,    rready_d;
  logic                rspvalid_q,  rspvalid_d;
  logic [DATA_W-1:0]   rsprdata_q,  rsprdata_d;
  resp_t               rspresp_q,   rspresp_d;
  logic                timeout_q,   timeout_d;

  logic                accept;
  logic                wdog_clr;
  logic                wdog_en;
  logic                wdog_expired;

  assign accept   = cmd_valid && cmd_ready_q;
  // Restart the watchdog on every state change so each phase gets a full budget.
  assign wdog_clr = (state_d != state_q);
  assign wdog_en  = is_wait_state(state_q);

  axi4lite_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk_i     (A_CLK),
    .rst_i     (A_RST),
    .clr_i     (wdog_clr),
    .en_i      (wdog_en),
    .expired_o (wdog_expired)
  );

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    awaddr_d    = awaddr_q;
    awprot_d    = awprot_q;
    awvalid_d   = awvalid_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    araddr_d    = araddr_q;
    arprot_d    = arprot_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rspvalid_d  = rspvalid_q;
    rsprdata_d  = rsprdata_q;
    rspresp_d   = rspresp_q;
    timeout_d   = timeout_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          timeout_d = 1'b0;
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            awprot_d  = cmd_prot;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            araddr_d  = cmd_addr;
            arprot_d  = cmd_prot;
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end

      WR: begin
        // Address and data channels retire independently; either may finish first.
        if (awvalid_q && AW_READY) begin
          awvalid_d = 1'b0;
        end
        if (wvalid_q && W_READY) begin
          wvalid_d = 1'b0;
        end
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (B_VALID && bready_q) begin
          rspresp_d  = resp_t'(B_RESP);
          rsprdata_d = '0;
          bready_d   = 1'b0;
          rspvalid_d = 1'b1;
          state_d    = RSP;
        end
      end

      RD_ADDR: begin
        if (arvalid_q && AR_READY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (R_VALID && rready_q) begin
          rsprdata_d = R_DATA;
          rspresp_d  = resp_t'(R_RESP);
          rready_d   = 1'b0;
          rspvalid_d = 1'b1;
          state_d    = RSP;
        end
      end

      RSP: begin
        if (rsp_ready) begin
          rspvalid_d = 1'b0;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A stalled bus phase latches the flag; only the next accepted command clears it.
    if (wdog_expired && is_wait_state(state_q)) begin
      timeout_d = 1'b1;
    end

    cmd_ready_d = (state_d == IDLE);
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge A_CLK or posedge A_RST) begin
    if (A_RST) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      awaddr_q    <= '0;
      awprot_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      araddr_q    <= '0;
      arprot_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rspvalid_q  <= 1'b0;
      rsprdata_q  <= '0;
      rspresp_q   <= OKAY;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awaddr_q    <= awaddr_d;
      awprot_q    <= awprot_d;
      awvalid_q   <= awvalid_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      araddr_q    <= araddr_d;
      arprot_q    <= arprot_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rspvalid_q  <= rspvalid_d;
      rsprdata_q  <= rsprdata_d;
      rspresp_q   <= rspresp_d;
      timeout_q   <= timeout_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rspvalid_q;
  assign rsp_rdata = rsprdata_q;
  assign rsp_resp  = rspresp_q;
  assign timeout   = timeout_q;
  assign AW_ADDR   = awaddr_q;
  assign AW_PROT   = awprot_q;
  assign AW_VALID  = awvalid_q;
  assign W_DATA    = wdata_q;
  assign W_STRB    = wstrb_q;
  assign W_VALID   = wvalid_q;
  assign B_READY   = bready_q;
  assign AR_ADDR   = araddr_q;
  assign AR_PROT   = arprot_q;
  assign AR_VALID  = arvalid_q;
  assign R_READY   = rready_q;

endmodule
